alu_result_fifo: RTL and testbench

- Downstream stage of the ALU top: consumes the four unit result buses and their valid flags.
- Detects each new result, packs it with a unit tag and carry into one word, and buffers it in a small FIFO.
- Drains to the next consumer (register writeback or bus) via a valid/ready handshake.
- Decouples ALU issue rate from consumer back-pressure and flags overflow and protocol errors.

---
 rtl/alu_result_fifo.sv | 161 ++++++++++++++++
 tb/tb_alu_result_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Captures new ALU unit results (change-detected), tags and packs them, and queues them for a valid/ready consumer.
// Optional per-unit capture counters on stat_cnt are enabled by defining ALU_RES_STATS_EN.
module alu_result_fifo #(
  parameter int OPR_W  = 16,
  parameter int RES_W  = 32,
  parameter int DEPTH  = 4,
  parameter int STAT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       arith_flag,
  input  logic                       logic_flag,
  input  logic                       cmp_flag,
  input  logic                       shift_flag,
  input  logic                       carry_out,
  input  logic [RES_W-1:0]           arith_out,
  input  logic [OPR_W-1:0]           logic_out,
  input  logic [OPR_W-1:0]           cmp_out,
  input  logic [OPR_W-1:0]           shift_out,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [RES_W-1:0]           out_data,
  output logic [1:0]                 out_tag,
  output logic                       out_carry,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       multi_flag_err
`ifdef ALU_RES_STATS_EN
  , output logic [4*STAT_W-1:0]      stat_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = RES_W + 3;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             mfe_q, mfe_d;
  logic             last_vld_q, last_vld_d;
  logic [1:0]       last_tag_q, last_tag_d;
  logic [RES_W-1:0] last_data_q, last_data_d;

  logic [1:0]       sel_tag;
  logic [RES_W-1:0] sel_data;
  logic             sel_carry;
  logic             any_flag, multi_flag, capture, push, pop;
  logic [2:0]       flag_sum;

  always_comb begin
    sel_tag   = 2'd0;
    sel_data  = '0;
    sel_carry = 1'b0;
    if (arith_flag) begin
      sel_data  = arith_out;
      sel_carry = carry_out;
    end else if (logic_flag) begin
      sel_tag                = 2'd1;
      sel_data[OPR_W-1:0]    = logic_out;
    end else if (cmp_flag) begin
      sel_tag                = 2'd2;
      sel_data[OPR_W-1:0]    = cmp_out;
    end else if (shift_flag) begin
      sel_tag                = 2'd3;
      sel_data[OPR_W-1:0]    = shift_out;
    end
  end

  assign flag_sum   = {2'b00, arith_flag} + {2'b00, logic_flag} + {2'b00, cmp_flag} + {2'b00, shift_flag};
  assign any_flag   = (flag_sum != 3'd0);
  assign multi_flag = (flag_sum > 3'd1);

  // The ALU holds its outputs, so only a changed (or re-asserted) result is new.
  assign capture = any_flag && (!last_vld_q || (sel_tag != last_tag_q) || (sel_data != last_data_q));

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign out_valid  = !empty;
  assign fifo_count = count_q;
  assign pop        = out_valid && out_ready;
  assign push       = capture && (!full || pop);

  assign out_data  = mem_q[rd_ptr_q][RES_W-1:0];
  assign out_tag   = mem_q[rd_ptr_q][RES_W+1:RES_W];
  assign out_carry = mem_q[rd_ptr_q][RES_W+2];
  assign overflow       = overflow_q;
  assign multi_flag_err = mfe_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (capture && full && !pop);
    mfe_d       = mfe_q | multi_flag;
    last_vld_d  = any_flag;
    last_tag_d  = any_flag ? sel_tag : last_tag_q;
    last_data_d = any_flag ? sel_data : last_data_q;
    if (push) begin
      mem_d[wr_ptr_q] = {sel_carry, sel_tag, sel_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      mfe_q       <= 1'b0;
      last_vld_q  <= 1'b0;
      last_tag_q  <= 2'd0;
      last_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      mfe_q       <= mfe_d;
      last_vld_q  <= last_vld_d;
      last_tag_q  <= last_tag_d;
      last_data_q <= last_data_d;
    end
  end

`ifdef ALU_RES_STATS_EN
  // Counters see every capture, dropped ones included, and stick at all-ones.
  logic [STAT_W-1:0] stat_q [4];
  logic [STAT_W-1:0] stat_d [4];

  always_comb begin
    stat_d = stat_q;
    if (capture && (stat_q[sel_tag] != '1)) stat_d[sel_tag] = stat_q[sel_tag] + STAT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo: vector table plus hand-written full/overflow/reset sequences.
module tb_alu_result_fifo;

  logic        CLK = 1'b0;
  logic        RST;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag, carry_out;
  logic [31:0] arith_out;
  logic [15:0] logic_out, cmp_out, shift_out;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        out_carry;
  logic [2:0]  fifo_count;
  logic        full, empty, overflow, multi_flag_err;
`ifdef ALU_RES_STATS_EN
  logic [31:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_result_fifo dut (
    .CLK(CLK), .RST(RST),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .carry_out(carry_out), .arith_out(arith_out),
    .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_carry(out_carry), .fifo_count(fifo_count), .full(full), .empty(empty),
    .overflow(overflow), .multi_flag_err(multi_flag_err)
`ifdef ALU_RES_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  flags;      // {shift, cmp, logic, arith}
    logic        carry;
    logic [31:0] a;
    logic [15:0] opr;        // drives logic/cmp/shift buses
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_tag;
    logic        exp_carry;
    logic [2:0]  exp_cnt;
    logic        exp_mfe;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic c, input logic [31:0] a,
                       input logic [15:0] o, input logic r);
    {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
    carry_out = c;
    arith_out = a;
    logic_out = o;
    cmp_out   = o;
    shift_out = o;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] d, input logic [1:0] t);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_tag"}, {30'd0, out_tag}, {30'd0, t});
  endtask

  logic [15:0] cmp_seq [5];
  logic [2:0]  cmp_cnt [5];
  logic        cmp_ovf [5];
  logic [31:0] drain_d [3];
  logic [1:0]  drain_t [3];

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 32'd12,         16'h0000, 1'b1, 1'b1, 32'h0000000C, 2'd0, 1'b0, 3'd1, 1'b0};
    vecs[1]  = '{4'b0001, 1'b0, 32'd12,         16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{4'b0001, 1'b0, 32'd12,         16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{4'b0001, 1'b0, 32'd12,         16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b0};
    vecs[4]  = '{4'b0001, 1'b0, 32'd12,         16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{4'b0001, 1'b1, 32'hFFFFFFF4,   16'h0000, 1'b0, 1'b1, 32'hFFFFFFF4, 2'd0, 1'b1, 3'd1, 1'b0};
    vecs[6]  = '{4'b0010, 1'b1, 32'hFFFFFFF4,   16'hFFF3, 1'b0, 1'b1, 32'hFFFFFFF4, 2'd0, 1'b1, 3'd2, 1'b0};
    vecs[7]  = '{4'b0000, 1'b1, 32'hFFFFFFF4,   16'hFFF3, 1'b1, 1'b1, 32'h0000FFF3, 2'd1, 1'b0, 3'd1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 32'd0,          16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{4'b0101, 1'b0, 32'd32,         16'h0005, 1'b0, 1'b1, 32'h00000020, 2'd0, 1'b0, 3'd1, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 32'd32,         16'h0005, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b1};
    vecs[11] = '{4'b0001, 1'b0, 32'd32,         16'h0000, 1'b0, 1'b1, 32'h00000020, 2'd0, 1'b0, 3'd1, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 32'd32,         16'h0000, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 3'd0, 1'b1};

    cmp_seq = '{16'd0, 16'd2, 16'd0, 16'd1, 16'd2};
    cmp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    cmp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drain_d = '{32'd0, 32'd1, 32'd16};
    drain_t = '{2'd2, 2'd2, 2'd3};

    RST = 1'b0;
    drive(4'b0000, 1'b0, 32'd0, 16'd0, 1'b1);
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_tag", {30'd0, out_tag}, 32'd0);
    chk("rst_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_mfe", {31'd0, multi_flag_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].flags, vecs[i].carry, vecs[i].a, vecs[i].opr, vecs[i].ready);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_mfe", i), {31'd0, multi_flag_err}, {31'd0, vecs[i].exp_mfe});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, 32'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
        chk($sformatf("v%0d_tag", i), {30'd0, out_tag}, {30'd0, vecs[i].exp_tag});
        chk($sformatf("v%0d_carry", i), {31'd0, out_carry}, {31'd0, vecs[i].exp_carry});
      end
    end

    // Fill past capacity with stalled consumer: fifth result is dropped.
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0, 32'd0, cmp_seq[i], 1'b0);
      step();
      chk($sformatf("cmp%0d_count", i), {29'd0, fifo_count}, {29'd0, cmp_cnt[i]});
      chk($sformatf("cmp%0d_ovf", i), {31'd0, overflow}, {31'd0, cmp_ovf[i]});
    end
    chk("full_flag", {31'd0, full}, 32'd1);
    chk_head("full_head", 32'd0, 2'd2);

    // Push and pop in the same cycle while full.
    drive(4'b1000, 1'b0, 32'd0, 16'd16, 1'b1);
    step();
    chk("pp_count", {29'd0, fifo_count}, 32'd4);
    chk("pp_full", {31'd0, full}, 32'd1);
    chk("pp_ovf", {31'd0, overflow}, 32'd1);
    chk_head("pp_head", 32'd2, 2'd2);

    drive(4'b0000, 1'b0, 32'd0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head($sformatf("drain%0d", i), drain_d[i], drain_t[i]);
    end
    step();
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_RES_STATS_EN
    chk("stat_cnt", stat_cnt, {8'd1, 8'd5, 8'd1, 8'd4});
`endif

    // Async reset mid-cycle with two entries queued.
    drive(4'b0001, 1'b0, 32'd7, 16'd0, 1'b0);
    step();
    drive(4'b0010, 1'b0, 32'd7, 16'd9, 1'b0);
    step();
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    drive(4'b0000, 1'b0, 32'd0, 16'd0, 1'b0);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {29'd0, fifo_count}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_mfe", {31'd0, multi_flag_err}, 32'd0);
    chk("arst_data", out_data, 32'd0);
`ifdef ALU_RES_STATS_EN
    chk("arst_stat", stat_cnt, 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("post_rst_count", {29'd0, fifo_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
